// File: rtl/ring_meas_sched.sv
// Round-robin measurement scheduler: walks the enabled ring/capture channels,
// opening a gate window, waiting for capture-done and strobing the result latch.
module ring_meas_sched #(
  parameter int pCHANNELS = 5,
  parameter int pGATE     = 1000,
  parameter int pTIMEOUT  = 4095,
  parameter int pIDXW     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_run,
  input  logic                 i_single,
  input  logic [pCHANNELS-1:0] i_mask,
  input  logic [pCHANNELS-1:0] i_done,
  output logic [pCHANNELS-1:0] o_start,
  output logic [pCHANNELS-1:0] o_gate,
  output logic [pIDXW-1:0]     o_sel,
  output logic                 o_latch,
  output logic                 o_busy,
  output logic [pCHANNELS-1:0] o_timeout,
  output logic                 o_pass_done
);

  localparam int pMAXCNT = (pGATE > pTIMEOUT) ? pGATE : pTIMEOUT;
  localparam int pCNTW   = $clog2(pMAXCNT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_GATE  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  logic [2:0]           r_state;
  logic [pIDXW-1:0]     r_sel;
  logic [pCHANNELS-1:0] r_mask;
  logic [pCHANNELS-1:0] r_timeout;
  logic [pCNTW-1:0]     r_cnt;

  logic                 w_first_found;
  logic [pIDXW-1:0]     w_first_idx;
  logic                 w_next_found;
  logic [pIDXW-1:0]     w_next_idx;
  logic [pCHANNELS-1:0] w_sel_onehot;
  logic                 w_cnt_zero;

  // Descending scans so the last hit is the lowest qualifying index.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int k = pCHANNELS - 1; k >= 0; k--) begin
      if (i_mask[k]) begin
        w_first_found = 1'b1;
        w_first_idx   = pIDXW'(k);
      end
      if (r_mask[k] && (k > int'(r_sel))) begin
        w_next_found = 1'b1;
        w_next_idx   = pIDXW'(k);
      end
    end
  end

  assign w_sel_onehot = {{(pCHANNELS-1){1'b0}}, 1'b1} << r_sel;
  assign w_cnt_zero   = (r_cnt == '0);

  // Strobes decode straight from state so an async reset clears them at once.
  assign o_start     = (r_state == S_START) ? w_sel_onehot : '0;
  assign o_gate      = (r_state == S_GATE)  ? w_sel_onehot : '0;
  assign o_latch     = (r_state == S_LATCH);
  assign o_busy      = (r_state != S_IDLE);
  assign o_pass_done = (r_state == S_NEXT) && !w_next_found;
  assign o_sel       = r_sel;
  assign o_timeout   = r_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_mask    <= '0;
      r_timeout <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((i_run || i_single) && w_first_found) begin
            r_state   <= S_START;
            r_sel     <= w_first_idx;
            r_mask    <= i_mask;
            r_timeout <= '0;
          end
        end
        S_START: begin
          r_cnt   <= pCNTW'(pGATE - 1);
          r_state <= S_GATE;
        end
        S_GATE: begin
          if (w_cnt_zero) begin
            r_cnt   <= pCNTW'(pTIMEOUT - 1);
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (i_done[r_sel]) begin
            r_state <= S_LATCH;
          end else if (w_cnt_zero) begin
            r_timeout[r_sel] <= 1'b1;
            r_state          <= S_LATCH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LATCH: begin
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_next_found) begin
            r_sel   <= w_next_idx;
            r_state <= S_START;
          end else if (i_run && w_first_found) begin
            // Back-to-back pass: fresh mask snapshot, timeout flags kept.
            r_mask  <= i_mask;
            r_sel   <= w_first_idx;
            r_state <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_meas_sched.sv
// Self-checking bench for ring_meas_sched: table of single passes plus
// hand-written run, empty-mask, busy-single and async-reset sequences.
module tb_ring_meas_sched;

  localparam int CH   = 5;
  localparam int GATE = 4;
  localparam int TMO  = 8;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic            single = 1'b0;
  logic [CH-1:0]   mask = '0;
  logic [CH-1:0]   dbg_done = '0;
  logic [CH-1:0]   rsp_done;
  logic [CH-1:0]   i_done;
  logic [CH-1:0]   o_start, o_gate, o_timeout;
  logic [IDXW-1:0] o_sel;
  logic            o_latch, o_busy, o_pass_done;

  assign i_done = rsp_done | dbg_done;

  ring_meas_sched #(.pCHANNELS(CH), .pGATE(GATE), .pTIMEOUT(TMO), .pIDXW(IDXW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_single(single),
    .i_mask(mask), .i_done(i_done), .o_start(o_start), .o_gate(o_gate),
    .o_sel(o_sel), .o_latch(o_latch), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_pass_done(o_pass_done)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int lat; bit tmo; } exp_t;
  typedef struct { logic [CH-1:0] mask; int dly; logic [CH-1:0] exp_tmo; int exp_passes; } vec_t;

  exp_t exq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   done_dly = 1;     // cycles after gate close before done rises; 0 = never
  int   st_cyc = 0;
  int   gw[CH];
  int   dcnt[CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or bound expired (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Capture-channel model: done rises done_dly cycles after the gate closes.
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_done = '0;
      for (int k = 0; k < CH; k++) dcnt[k] = -1;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (o_start[k]) begin
          rsp_done[k] = 1'b0;
          dcnt[k] = -1;
        end else if (o_gate[k]) begin
          dcnt[k] = 0;
        end else if (dcnt[k] >= 0) begin
          dcnt[k]++;
          if (done_dly > 0 && dcnt[k] >= done_dly) rsp_done[k] = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) gw[k] = 0;
    end else begin
      if (o_start != '0) begin
        st_cyc = cyc;
        if (exq.size() == 0) fail_now("start_unexpected");
        else chk("start_ch", {27'd0, o_start}, 32'(1) << exq[0].ch);
      end
      if (o_gate != '0 && exq.size() != 0)
        chk("gate_ch", {27'd0, o_gate}, 32'(1) << exq[0].ch);
      for (int k = 0; k < CH; k++) begin
        if (o_gate[k]) gw[k]++;
        else if (gw[k] > 0) begin
          chk("gate_width", gw[k], GATE);
          gw[k] = 0;
        end
      end
      if (o_latch) begin
        if (exq.size() == 0) fail_now("latch_unexpected");
        else begin
          mon_e = exq.pop_front();
          $display("latch ch=%0d sel=%0d lat=%0d tmo=%b", mon_e.ch, o_sel, cyc - st_cyc, o_timeout);
          chk("latch_sel", {29'd0, o_sel}, mon_e.ch);
          chk("latch_latency", cyc - st_cyc, mon_e.lat);
          chk("latch_timeout", {31'd0, o_timeout[mon_e.ch]}, {31'd0, mon_e.tmo});
        end
      end
      if (o_pass_done) pass_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_pass(input logic [CH-1:0] m);
    for (int k = 0; k < CH; k++)
      if (m[k]) exq.push_back('{ch: k, lat: (done_dly == 0) ? GATE + 1 + TMO : GATE + 1 + done_dly,
                                tmo: (done_dly == 0)});
  endtask

  task automatic pulse_single();
    single = 1'b1;
    tick(1);
    single = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick(1);
      n++;
    end
    if (o_busy) fail_now(name);
  endtask

  task automatic wait_passes(input string name, input int target, input int budget);
    int n = 0;
    while (pass_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    if (pass_cnt < target) fail_now(name);
  endtask

  vec_t tbl[6];
  int   p0;

  initial begin
    tbl[0] = '{mask: 5'b10101, dly: 2, exp_tmo: 5'b00000, exp_passes: 1};
    tbl[1] = '{mask: 5'b00010, dly: 0, exp_tmo: 5'b00010, exp_passes: 1};
    tbl[2] = '{mask: 5'b00000, dly: 1, exp_tmo: 5'b00010, exp_passes: 0};
    tbl[3] = '{mask: 5'b11111, dly: 1, exp_tmo: 5'b00000, exp_passes: 1};
    tbl[4] = '{mask: 5'b01001, dly: 3, exp_tmo: 5'b00000, exp_passes: 1};
    tbl[5] = '{mask: 5'b10000, dly: 0, exp_tmo: 5'b10000, exp_passes: 1};

    // Reset with random inputs: all outputs held at 0.
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom); single = 1'($urandom);
      mask = CH'($urandom); dbg_done = CH'($urandom);
      tick(1);
      chk("rst_outputs", {o_start, o_gate, o_timeout, o_sel, o_latch, o_busy, o_pass_done}, 0);
    end
    run = 1'b0; single = 1'b0; dbg_done = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rst_release_busy", {31'd0, o_busy}, 0);
    end

    // Single passes from the table.
    for (int i = 0; i < 6; i++) begin
      done_dly = tbl[i].dly;
      mask = tbl[i].mask;
      p0 = pass_cnt;
      push_pass(tbl[i].mask);
      pulse_single();
      wait_idle("vec_idle_timeout", 400);
      tick(3);
      $display("vector %0d mask=%b passes=%0d tmo=%b", i, tbl[i].mask, pass_cnt - p0, o_timeout);
      chk("vec_passes", pass_cnt - p0, tbl[i].exp_passes);
      chk("vec_timeout", {27'd0, o_timeout}, {27'd0, tbl[i].exp_tmo});
      chk("vec_queue_empty", exq.size(), 0);
    end

    // Continuous run with a mid-pass mask change, then run dropped.
    done_dly = 1;
    mask = 5'b00011;
    p0 = pass_cnt;
    push_pass(5'b00011);
    push_pass(5'b00011);
    run = 1'b1;
    wait_passes("run_pass1", p0 + 1, 300);
    tick(1);
    chk("run_no_gap_busy", {31'd0, o_busy}, 1);
    chk("run_restart_ch0", {27'd0, o_start}, 5'b00001);
    mask = 5'b00100;
    push_pass(5'b00100);
    wait_passes("run_pass2", p0 + 2, 300);
    tick(1);
    chk("run_newmask_ch2", {27'd0, o_start}, 5'b00100);
    run = 1'b0;
    wait_idle("run_idle", 300);
    tick(2);
    $display("run sequence passes=%0d", pass_cnt - p0);
    chk("run_passes", pass_cnt - p0, 3);
    chk("run_queue_empty", exq.size(), 0);

    // Empty mask: no pass, no busy.
    mask = '0;
    p0 = pass_cnt;
    pulse_single();
    for (int i = 0; i < 4; i++) begin
      chk("empty_busy", {31'd0, o_busy}, 0);
      tick(1);
    end
    chk("empty_passes", pass_cnt - p0, 0);

    // i_single while busy is ignored.
    mask = 5'b00001;
    p0 = pass_cnt;
    push_pass(5'b00001);
    pulse_single();
    tick(2);
    pulse_single();
    wait_idle("busy_single_idle", 300);
    tick(4);
    $display("busy single passes=%0d", pass_cnt - p0);
    chk("busy_single_passes", pass_cnt - p0, 1);
    chk("busy_single_queue", exq.size(), 0);

    // Async reset in the middle of a gate window on channel 3.
    mask = 5'b01000;
    push_pass(5'b01000);
    pulse_single();
    begin
      int n = 0;
      while (!o_gate[3] && n < 50) begin
        tick(1);
        n++;
      end
      if (!o_gate[3]) fail_now("arst_gate_wait");
    end
    tick(1);
    rst_n = 1'b0;
    #1;
    $display("async reset gate=%b start=%b busy=%b", o_gate, o_start, o_busy);
    chk("arst_gate", {27'd0, o_gate}, 0);
    chk("arst_start", {27'd0, o_start}, 0);
    chk("arst_busy", {31'd0, o_busy}, 0);
    exq.delete();
    tick(2);
    rst_n = 1'b1;
    run = 1'b0;
    tick(3);
    chk("arst_release_busy", {31'd0, o_busy}, 0);
    chk("arst_release_sel", {29'd0, o_sel}, 0);
    chk("arst_release_tmo", {27'd0, o_timeout}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_meas_sched.md
Name: ring_meas_sched

Overview:
Round-robin measurement scheduler for the ring-oscillator capture channels. It runs in the i_clk domain and shares one measurement slot between up to pCHANNELS ring/capture channels. For each enabled channel it opens a gate window of pGATE i_clk cycles, then waits for that channel's capture-done flag (already synchronized into i_clk). It then pulses a latch strobe so the scan/LED stage can register the result, and advances to the next enabled channel.

Parameters:
pCHANNELS, 5, number of channels; 2..8
pGATE, 1000, gate-window length in i_clk cycles; >=1
pTIMEOUT, 4095, maximum i_clk cycles to wait for i_done after the gate closes; >=1
pIDXW, 3, width of the channel index; must satisfy 2**pIDXW >= pCHANNELS

Ports:
i_clk  in  1  system clock (the io_in[0] clock)
i_rst_n  in  1  asynchronous, active-low reset
i_run  in  1  level; while high, passes repeat continuously
i_single  in  1  one-cycle pulse; runs exactly one pass
i_mask  in  pCHANNELS  channel enable; bit k=1 means channel k is included
i_done  in  pCHANNELS  per-channel capture-complete level, synchronized into i_clk
o_start  out  pCHANNELS  one-hot, one-cycle pulse that clears/arms the channel's capture
o_gate  out  pCHANNELS  one-hot level, high for exactly pGATE cycles
o_sel  out  pIDXW  index of the current (or last) channel
o_latch  out  1  one-cycle strobe; the result for o_sel is valid
o_busy  out  1  high whenever the state is not IDLE
o_timeout  out  pCHANNELS  sticky per-channel timeout flags
o_pass_done  out  1  one-cycle pulse at the end of each pass

Behaviour:
- Reset, asynchronous on i_rst_n low: state=IDLE; all outputs are 0, including o_sel and o_timeout. Release is synchronous to the next i_clk edge.
- States are IDLE, START, GATE, WAIT, LATCH, NEXT.
- Pass start:
  - IDLE leaves when (i_run | i_single) and the i_mask snapshot is nonzero.
  - i_mask is snapshotted into m_mask at pass start. Changes to i_mask mid-pass are ignored until the next pass.
  - The pass begins at the lowest-index set bit of m_mask.
  - If the mask is zero, the block stays in IDLE. No o_pass_done is produced.
- IDLE->START: on the transition edge, o_sel is set to the first channel.
- START: one cycle; o_start[o_sel]=1. Gate counter is loaded to pGATE-1. Next state is GATE.
- GATE: o_gate[o_sel]=1 for exactly pGATE cycles, with the counter decrementing. Then go to WAIT and load the timeout counter to pTIMEOUT-1.
- WAIT: on the first cycle with i_done[o_sel]=1, go to LATCH.
  - If the counter reaches 0 without i_done, set o_timeout[o_sel]=1 and go to LATCH anyway.
  - i_done on channels other than o_sel is ignored.
- LATCH: one cycle; o_latch=1 with o_sel stable. Next state is NEXT.
- NEXT: one cycle. Search m_mask for the next set bit with index > o_sel.
  - If one is found: o_sel takes that index; go to START.
  - Otherwise: o_pass_done=1. If i_run=1, re-snapshot i_mask and go to START at its lowest set bit, or to IDLE if the new mask is zero. If i_run=0, go to IDLE.
- Minimum per-channel latency, START to o_latch: 1 + pGATE + 1 (done seen on first WAIT cycle) + 0 = pGATE+2 cycles from the o_start cycle to the o_latch cycle.
- i_single while busy: ignored. No queuing.
- i_run and i_single together: treated as i_run.
- i_run dropped mid-pass: the current pass completes, then the block goes to IDLE.
- o_timeout flags:
  - Cleared only by reset, or at the start of a pass launched from IDLE.
  - Retained across back-to-back i_run passes.
- Counters are sized to hold max(pGATE, pTIMEOUT). They never wrap; the decrement stops at 0.
- Reset asserted mid-gate forces o_gate/o_start to 0 immediately, without waiting for a clock edge.

Test Plan:
1. Reset values: hold i_rst_n=0 with random inputs -> every output is 0. Release with i_run=0 -> o_busy stays 0.
2. Single pass, pGATE=4, i_mask=5'b10101, i_done asserted 2 cycles after each gate closes:
   - o_start fires on channels 0, 2, 4 in order.
   - Each o_gate is 4 cycles wide.
   - o_latch fires with o_sel=0, then 2, then 4.
   - o_pass_done fires once, then the block returns to IDLE.
3. Timeout, pTIMEOUT=8, i_mask=5'b00010, i_done held 0:
   - o_latch fires 8 cycles after the gate closes.
   - o_timeout=5'b00010, sticky until the next pass from IDLE.
4. Continuous run, i_run=1, i_mask=5'b00011:
   - Passes repeat with no IDLE gap.
   - Change i_mask to 5'b00100 mid-pass -> the current pass still covers channels 0 and 1; the next pass covers channel 2 only.
   - Drop i_run -> the pass finishes and the block goes to IDLE.
5. Empty mask: i_mask=0 with i_single pulse -> o_busy stays 0 and no o_pass_done. Also, i_single while busy is ignored (exactly one pass).
6. Async reset mid-GATE on channel 3: o_gate drops without a clock edge. After release with i_run=0 -> IDLE and o_sel=0.
